otter_ctrl_fsm: RTL

Multicycle control unit for the Otter MCU. It is the sequencing side of the ALU interface: it fetches, decodes the instruction register and drives alu_fun, the ALU operand selects, PC/register-file/memory strobes and mux selects. The ALU, register file, memory, PC and branch-condition generator live in the datapath and consume these signals.

---
 rtl/otter_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/otter_ctrl_fsm.sv
// otter_ctrl_fsm: multicycle control unit for the Otter MCU.
// Sequences FETCH -> EXEC (-> WRITEBACK for loads) and decodes the
// instruction register into ALU, mux-select and strobe signals for the datapath.
// Optional interrupt support is compiled in with the OTTER_INTR_EN macro.
module otter_ctrl_fsm #(
    parameter int RESET_STATE_ONLY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
`ifdef OTTER_INTR_EN
    input  logic        intr,
    output logic        int_taken,
`endif
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_rden1,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic [3:0]  alu_fun,
    output logic        srcA_sel,
    output logic [1:0]  srcB_sel,
    output logic [2:0]  pc_sel,
    output logic [1:0]  rf_wr_sel,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        EXEC      = 2'd1,
        WRITEBACK = 2'd2,
        INTR      = 2'd3
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
`ifdef OTTER_INTR_EN
    localparam logic [31:0] IR_MRET   = 32'h30200073;
`endif

    state_t state;
    state_t next_state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b;
    logic       br_taken;
    logic       end_of_instr_intr;
    logic       unused_ir;

    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign f7b     = ir[30];
    assign state_o = state;

    // Bits of ir that only matter to the datapath (register indices, immediates).
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

`ifdef OTTER_INTR_EN
    assign end_of_instr_intr = intr;
`else
    assign end_of_instr_intr = 1'b0;
`endif

    // Branch condition select from funct3; funct3 010/011 never branch.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = ~br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = ~br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = ~br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // State register; reset lands in FETCH, aborting any instruction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n || (RESET_STATE_ONLY != 0)) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and decode outputs; everything is forced to 0 while in reset.
    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_rden1  = 1'b0;
        mem_rden2  = 1'b0;
        mem_we2    = 1'b0;
        alu_fun    = 4'b0000;
        srcA_sel   = 1'b0;
        srcB_sel   = 2'd0;
        pc_sel     = 3'd0;
        rf_wr_sel  = 2'd0;
`ifdef OTTER_INTR_EN
        int_taken  = 1'b0;
`endif

        case (state)
            FETCH: begin
                mem_rden1  = 1'b1;
                next_state = EXEC;
            end

            EXEC: begin
                next_state = end_of_instr_intr ? INTR : FETCH;
                case (opcode)
                    OPC_OP: begin
                        alu_fun   = {f7b, funct3};
                        srcB_sel  = 2'd0;
                        rf_wr_sel = 2'd3;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OPC_OPIMM: begin
                        alu_fun   = {(funct3 == 3'b101) ? f7b : 1'b0, funct3};
                        srcB_sel  = 2'd1;
                        rf_wr_sel = 2'd3;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OPC_LUI: begin
                        alu_fun   = 4'b1001;
                        srcA_sel  = 1'b1;
                        rf_wr_sel = 2'd3;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OPC_AUIPC: begin
                        alu_fun   = 4'b0000;
                        srcA_sel  = 1'b1;
                        srcB_sel  = 2'd3;
                        rf_wr_sel = 2'd3;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OPC_JAL: begin
                        pc_sel    = 3'd3;
                        rf_wr_sel = 2'd0;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OPC_JALR: begin
                        pc_sel    = 3'd1;
                        rf_wr_sel = 2'd0;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OPC_BRANCH: begin
                        pc_sel   = br_taken ? 3'd2 : 3'd0;
                        pc_write = 1'b1;
                    end
                    OPC_LOAD: begin
                        alu_fun    = 4'b0000;
                        srcB_sel   = 2'd1;
                        mem_rden2  = 1'b1;
                        next_state = WRITEBACK;
                    end
                    OPC_STORE: begin
                        alu_fun  = 4'b0000;
                        srcB_sel = 2'd2;
                        mem_we2  = 1'b1;
                        pc_write = 1'b1;
                    end
                    default: begin
                        pc_write = 1'b1;
                        pc_sel   = 3'd0;
`ifdef OTTER_INTR_EN
                        if (ir == IR_MRET) begin
                            pc_sel = 3'd5;
                        end
`endif
                    end
                endcase
            end

            WRITEBACK: begin
                reg_write  = 1'b1;
                rf_wr_sel  = 2'd2;
                pc_write   = 1'b1;
                pc_sel     = 3'd0;
                next_state = end_of_instr_intr ? INTR : FETCH;
            end

            default: begin
`ifdef OTTER_INTR_EN
                int_taken = 1'b1;
                pc_sel    = 3'd4;
                pc_write  = 1'b1;
`endif
                next_state = FETCH;
            end
        endcase

        if (!rst_n) begin
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_rden1 = 1'b0;
            mem_rden2 = 1'b0;
            mem_we2   = 1'b0;
            alu_fun   = 4'b0000;
            srcA_sel  = 1'b0;
            srcB_sel  = 2'd0;
            pc_sel    = 3'd0;
            rf_wr_sel = 2'd0;
`ifdef OTTER_INTR_EN
            int_taken = 1'b0;
`endif
        end
    end

endmodule
